// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared types for the CPU phase sequencer: phase encoding, strobe bundle
// and small helpers used by the sequencer and its wait timer.
package cpu_phase_sequencer_pkg;

  // Phase encoding is also the debug/trace value on the phase output.
  typedef enum logic [3:0] {
    PH_IDLE   = 4'd0,
    PH_FETCH  = 4'd1,
    PH_DECODE = 4'd2,
    PH_REGRD  = 4'd3,
    PH_EXEC   = 4'd4,
    PH_MEM    = 4'd5,
    PH_WBRES  = 4'd6,
    PH_WB     = 4'd7,
    PH_PCUPD  = 4'd8,
    PH_ERROR  = 4'd9
  } phase_e;

  localparam int NUM_STROBES = 8;

  // One bit per datapath phase strobe; at most one is ever set.
  typedef struct packed {
    logic update_pc;
    logic writeback;
    logic wb_resolve;
    logic access_mem;
    logic execute;
    logic reg_read;
    logic decode;
    logic fetch;
  } strobes_t;

  // Strobe pattern that accompanies entry into a given phase.
  function automatic strobes_t strobes_for(input phase_e ph);
    strobes_t s;
    s = '0;
    case (ph)
      PH_FETCH:  s.fetch      = 1'b1;
      PH_DECODE: s.decode     = 1'b1;
      PH_REGRD:  s.reg_read   = 1'b1;
      PH_EXEC:   s.execute    = 1'b1;
      PH_MEM:    s.access_mem = 1'b1;
      PH_WBRES:  s.wb_resolve = 1'b1;
      PH_WB:     s.writeback  = 1'b1;
      PH_PCUPD:  s.update_pc  = 1'b1;
      default:   s = '0;
    endcase
    return s;
  endfunction

  // The sequencer is busy while an instruction is in flight.
  function automatic logic is_busy(input phase_e ph);
    return !((ph == PH_IDLE) || (ph == PH_ERROR));
  endfunction

endpackage

// File: rtl/cpu_phase_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting on the data-memory handshake. The count is
// held at zero while clr is high and advances while en is high; expired
// flags the last permitted wait cycle (count == MEM_TIMEOUT-1).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // A one-cycle budget still needs a one-bit counter.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Wait counter: cleared outside the wait state, saturates at LAST.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LAST)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Clocked multi-cycle phase controller for the 8-bit CPU datapath. Issues
// one-cycle registered phase strobes, skips unused MEM/WB phases, waits on
// the data-memory handshake with a timeout, and supports run/step/halt.
module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ICNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              reg_w_en,
  input  logic              mem_ready,
  output logic              fetch,
  output logic              decode,
  output logic              reg_read,
  output logic              execute,
  output logic              access_mem,
  output logic              wb_resolve,
  output logic              writeback,
  output logic              update_pc,
  output logic [3:0]        phase,
  output logic              busy,
  output logic              mem_err,
  output logic [ICNT_W-1:0] icount
);

  phase_e            state_reg;
  phase_e            state_next;
  strobes_t          strobes_reg;
  logic              busy_reg;
  logic              pending_halt_reg;
  logic              step_mode_reg;
  logic              mem_err_reg;
  logic [ICNT_W-1:0] icount_reg;
  logic              mem_expired;
  logic              in_mem;

  assign in_mem = (state_reg == PH_MEM);

  // The timer restarts at zero on every MEM entry because it is held
  // clear in every other phase.
  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_mem),
    .en      (in_mem),
    .expired (mem_expired)
  );

  // Next-phase decision from the current phase and the sampled inputs.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PH_IDLE: begin
        if (halt_req || pending_halt_reg) begin
          state_next = PH_IDLE;
        end else if (run || step) begin
          state_next = PH_FETCH;
        end
      end
      PH_FETCH:  state_next = PH_DECODE;
      PH_DECODE: state_next = PH_REGRD;
      PH_REGRD:  state_next = PH_EXEC;
      PH_EXEC:   state_next = (mem_r_en || mem_w_en) ? PH_MEM : PH_WBRES;
      PH_MEM: begin
        // Ready wins over timeout, so ready on the last allowed cycle succeeds.
        if (mem_ready) begin
          state_next = PH_WBRES;
        end else if (mem_expired) begin
          state_next = PH_ERROR;
        end
      end
      PH_WBRES:  state_next = reg_w_en ? PH_WB : PH_PCUPD;
      PH_WB:     state_next = PH_PCUPD;
      PH_PCUPD: begin
        if (pending_halt_reg || halt_req || step_mode_reg || !run) begin
          state_next = PH_IDLE;
        end else begin
          state_next = PH_FETCH;
        end
      end
      PH_ERROR:  state_next = PH_ERROR;
      default:   state_next = PH_IDLE;
    endcase
  end

  // Phase register with registered strobes and busy; a strobe fires only
  // on the cycle its phase is entered, so a held MEM phase stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= PH_IDLE;
      strobes_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      strobes_reg <= (state_next != state_reg) ? strobes_for(state_next) : '0;
      busy_reg    <= is_busy(state_next);
    end
  end

  // Halt and single-step bookkeeping carried across an instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_halt_reg <= 1'b0;
      step_mode_reg    <= 1'b0;
    end else begin
      case (state_reg)
        PH_IDLE: begin
          pending_halt_reg <= 1'b0;
          if (state_next == PH_FETCH) begin
            step_mode_reg <= !run;
          end
        end
        PH_PCUPD: begin
          pending_halt_reg <= 1'b0;
          step_mode_reg    <= 1'b0;
        end
        default: begin
          if (halt_req) begin
            pending_halt_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky memory-timeout flag and the retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err_reg <= 1'b0;
      icount_reg  <= '0;
    end else begin
      if (in_mem && (state_next == PH_ERROR)) begin
        mem_err_reg <= 1'b1;
      end
      if (state_reg == PH_PCUPD) begin
        icount_reg <= icount_reg + ICNT_W'(1);
      end
    end
  end

  assign fetch      = strobes_reg.fetch;
  assign decode     = strobes_reg.decode;
  assign reg_read   = strobes_reg.reg_read;
  assign execute    = strobes_reg.execute;
  assign access_mem = strobes_reg.access_mem;
  assign wb_resolve = strobes_reg.wb_resolve;
  assign writeback  = strobes_reg.writeback;
  assign update_pc  = strobes_reg.update_pc;
  assign phase      = state_reg;
  assign busy       = busy_reg;
  assign mem_err    = mem_err_reg;
  assign icount     = icount_reg;

endmodule
